// File: rtl/ser_loader4.sv
// ser_loader4: serial-to-parallel word assembler with a downstream load strobe.
// Collects WIDTH valid serial bits after a start request. When the last bit
// is accepted it publishes the word on d_out and, in the next cycle, pulses
// load_en once so a downstream register can capture it.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset
//   start      begin a new word (only honoured when idle)
//   bit_valid  serial_in holds a valid bit this cycle
//   serial_in  serial data bit
//   abort      drop the word in progress (only while shifting)
//   d_out      last complete word; changes only when a word completes
//   load_en    one-cycle strobe for the downstream register enable
//   busy       high while shifting or loading
//   bit_cnt    bits accepted in the current word
module ser_loader4 #(
    parameter int unsigned WIDTH     = 4,
    parameter bit          MSB_FIRST = 1'b1,
    localparam int unsigned CntW     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             bit_valid,
    input  logic             serial_in,
    input  logic             abort,
    output logic [WIDTH-1:0] d_out,
    output logic             load_en,
    output logic             busy,
    output logic [CntW-1:0]  bit_cnt
);

    typedef enum logic [1:0] {StIdle, StShift, StLoad} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [WIDTH-1:0]  sr_shift;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic              load_q, load_d;
    logic              busy_q, busy_d;

    // MSB-first pushes bits in from the bottom so the first bit ends up on top;
    // LSB-first pushes in from the top so the first bit ends up at bit 0.
    assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], serial_in}
                                : {serial_in, sr_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        unique case (state_q)
            StIdle: begin
                // abort is meaningless here, so start always wins
                if (start) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    sr_d    = '0;
                end
            end
            StShift: begin
                // abort beats a valid bit in the same cycle
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (bit_valid) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StLoad;
                        dout_d  = sr_shift;
                    end
                end
            end
            StLoad: begin
                // start and abort are both ignored; bit_cnt keeps WIDTH
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        // Outputs are decoded from the next state so they come straight off flops.
        load_d = (state_d == StLoad);
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            sr_q    <= '0;
            cnt_q   <= '0;
            dout_q  <= '0;
            load_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            load_q  <= load_d;
            busy_q  <= busy_d;
        end
    end

    assign d_out   = dout_q;
    assign load_en = load_q;
    assign busy    = busy_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_ser_loader4.sv
// Bench for ser_loader4: one MSB-first and one LSB-first instance share stimulus.
// A word-level model (bit queue + arithmetic word assembly) predicts every
// output after every edge; a vector table and directed sequences add
// hand-computed expectations for the corner cases.
module tb_ser_loader4;

    localparam int W = 4;

    logic       clk = 1'b0;
    logic       reset, start, bit_valid, serial_in, abort;
    logic [3:0] dm, dl;
    logic       lm, ll, bm, bl;
    logic [2:0] cm, cl;

    int n_tests = 0;
    int n_fail  = 0;

    // model state: phase 0 idle, 1 collecting, 2 load cycle
    int ph = 0;
    int q[$];
    int m_dm = 0;
    int m_dl = 0;

    ser_loader4 #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .serial_in(serial_in), .abort(abort),
        .d_out(dm), .load_en(lm), .busy(bm), .bit_cnt(cm)
    );

    ser_loader4 #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset(reset), .start(start), .bit_valid(bit_valid),
        .serial_in(serial_in), .abort(abort),
        .d_out(dl), .load_en(ll), .busy(bl), .bit_cnt(cl)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit s, input bit bv, input bit si, input bit ab,
                              input bit rst);
        if (!rst) begin
            ph = 0;
            q.delete();
            m_dm = 0;
            m_dl = 0;
        end else begin
            case (ph)
                0: if (s) begin ph = 1; q.delete(); end
                1: begin
                    if (ab) begin
                        ph = 0;
                        q.delete();
                    end else if (bv) begin
                        q.push_back(int'(si));
                        if (q.size() == W) begin
                            m_dm = 0;
                            m_dl = 0;
                            foreach (q[i]) begin
                                m_dm = m_dm * 2 + q[i];
                                m_dl = m_dl + (q[i] << i);
                            end
                            ph = 2;
                        end
                    end
                end
                default: ph = 0;
            endcase
        end
    endtask

    task automatic check_model();
        chk("load_msb", 32'(lm), 32'(ph == 2));
        chk("load_lsb", 32'(ll), 32'(ph == 2));
        chk("busy_msb", 32'(bm), 32'(ph != 0));
        chk("busy_lsb", 32'(bl), 32'(ph != 0));
        chk("cnt_msb", 32'(cm), 32'(q.size()));
        chk("cnt_lsb", 32'(cl), 32'(q.size()));
        chk("dout_msb", 32'(dm), 32'(m_dm));
        chk("dout_lsb", 32'(dl), 32'(m_dl));
    endtask

    // Drive one cycle of inputs, take the edge, update the model, sample 1 time unit later.
    task automatic step(input bit s, input bit bv, input bit si, input bit ab, input bit rst);
        start     = s;
        bit_valid = bv;
        serial_in = si;
        abort     = ab;
        reset     = rst;
        @(posedge clk);
        model_edge(s, bv, si, ab, rst);
        #1;
        check_model();
    endtask

    typedef struct {
        bit s, bv, si, ab, rst;
        bit e_load, e_busy;
        int e_cnt, e_dm, e_dl;
    } vec_t;

    vec_t tbl[7];

    initial begin
        start = 1'b0; bit_valid = 1'b0; serial_in = 1'b0; abort = 1'b0; reset = 1'b0;

        // reset, then start + bits 1,0,1,1: load on the 5th edge counting the start edge
        tbl[0] = '{s:0, bv:0, si:0, ab:0, rst:0, e_load:0, e_busy:0, e_cnt:0, e_dm:0,   e_dl:0};
        tbl[1] = '{s:1, bv:1, si:1, ab:0, rst:1, e_load:0, e_busy:1, e_cnt:0, e_dm:0,   e_dl:0};
        tbl[2] = '{s:0, bv:1, si:1, ab:0, rst:1, e_load:0, e_busy:1, e_cnt:1, e_dm:0,   e_dl:0};
        tbl[3] = '{s:0, bv:1, si:0, ab:0, rst:1, e_load:0, e_busy:1, e_cnt:2, e_dm:0,   e_dl:0};
        tbl[4] = '{s:0, bv:1, si:1, ab:0, rst:1, e_load:0, e_busy:1, e_cnt:3, e_dm:0,   e_dl:0};
        tbl[5] = '{s:0, bv:1, si:1, ab:0, rst:1, e_load:1, e_busy:1, e_cnt:4, e_dm:'hb, e_dl:'hd};
        tbl[6] = '{s:0, bv:1, si:0, ab:0, rst:1, e_load:0, e_busy:0, e_cnt:4, e_dm:'hb, e_dl:'hd};

        for (int i = 0; i < 7; i++) begin
            step(tbl[i].s, tbl[i].bv, tbl[i].si, tbl[i].ab, tbl[i].rst);
            chk("tbl_load", 32'(lm), 32'(tbl[i].e_load));
            chk("tbl_busy", 32'(bm), 32'(tbl[i].e_busy));
            chk("tbl_cnt", 32'(cm), 32'(tbl[i].e_cnt));
            chk("tbl_dout_msb", 32'(dm), 32'(tbl[i].e_dm));
            chk("tbl_dout_lsb", 32'(dl), 32'(tbl[i].e_dl));
        end

        // stall: bits 1,1, three idle cycles, then 0,1 -> load on edge 8
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 1);
            chk("stall_cnt", 32'(cm), 32'd2);
            chk("stall_noload", 32'(lm), 32'd0);
        end
        step(0, 1, 0, 0, 1);
        chk("stall_early", 32'(lm), 32'd0);
        step(0, 1, 1, 0, 1);
        chk("stall_load", 32'(lm), 32'd1);
        chk("stall_dout_msb", 32'(dm), 32'hd);
        chk("stall_dout_lsb", 32'(dl), 32'hb);
        step(0, 0, 0, 0, 1);

        // abort after two bits, with bit_valid also high in the abort cycle
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 1, 1);
        chk("abort_busy", 32'(bm), 32'd0);
        chk("abort_cnt", 32'(cm), 32'd0);
        chk("abort_dout", 32'(dm), 32'hd);
        chk("abort_noload", 32'(lm), 32'd0);
        step(1, 0, 0, 0, 1);
        step(0, 1, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 0, 0, 1);
        chk("after_abort_load", 32'(lm), 32'd1);
        chk("after_abort_dout", 32'(dm), 32'h6);
        step(0, 0, 0, 0, 1);

        // reset mid-word after three bits, with every other input active
        step(1, 0, 0, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        step(0, 1, 1, 0, 1);
        step(1, 1, 1, 1, 0);
        chk("rst_dout", 32'(dm), 32'd0);
        chk("rst_busy", 32'(bm), 32'd0);
        chk("rst_cnt", 32'(cm), 32'd0);
        chk("rst_load", 32'(lm), 32'd0);
        step(1, 0, 0, 0, 1);
        chk("rst_first_start", 32'(bm), 32'd1);
        step(0, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) begin
            step(0, 1, 1, 0, 1);
            chk("rst_noload", 32'(lm), 32'd0);
        end

        // start held through the whole word and the load cycle; abort in load
        step(1, 0, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        step(1, 1, 0, 0, 1);
        chk("start_in_shift_cnt", 32'(cm), 32'd2);
        step(1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        chk("start_in_shift_load", 32'(lm), 32'd1);
        chk("start_in_shift_dout", 32'(dm), 32'h9);
        step(1, 0, 0, 1, 1);
        chk("start_in_load_busy", 32'(bm), 32'd0);
        chk("start_in_load_cnt", 32'(cm), 32'd4);
        step(0, 0, 0, 0, 1);
        chk("start_not_queued", 32'(bm), 32'd0);
        step(1, 0, 0, 1, 1);
        chk("start_beats_abort", 32'(bm), 32'd1);

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ser_loader4.md
SER_LOADER4 -- requirements
Module: ser_loader4

Interface
REQ-001 Parameter: WIDTH, 4, number of bits assembled per word (legal range 2..16).
REQ-002 Parameter: MSB_FIRST, 1, 1 = first received bit lands in d_out[WIDTH-1]; 0 = first bit lands in d_out[0].
REQ-003 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-005 Port: start  input  1  request to begin a new word; honoured only in IDLE.
REQ-006 Port: bit_valid  input  1  serial_in carries a valid bit this cycle.
REQ-007 Port: serial_in  input  1  serial data bit.
REQ-008 Port: abort  input  1  discard the word in progress.
REQ-009 Port: d_out  output  WIDTH  assembled parallel word, driven to the downstream register data input.
REQ-010 Port: load_en  output  1  one-cycle strobe, driven to the downstream register enable.
REQ-011 Port: busy  output  1  high while in SHIFT or LOAD.
REQ-012 Port: bit_cnt  output  clog2(WIDTH+1)  number of bits accepted in the current word.

Function
REQ-013 FSM states: IDLE, SHIFT, LOAD; all outputs registered.
REQ-014 IDLE -> SHIFT when start=1; bit_cnt cleared to 0 on the same edge; bit_valid in the start cycle is ignored.
REQ-015 In SHIFT, each cycle with bit_valid=1 shifts serial_in into the shift register per MSB_FIRST and increments bit_cnt.
REQ-016 In SHIFT, a cycle with bit_valid=0 holds the shift register and bit_cnt (stall); no timeout.
REQ-017 On the edge accepting bit WIDTH, SHIFT -> LOAD; d_out is updated to the complete word on that same edge.
REQ-018 In LOAD, load_en=1 for exactly one cycle; the next edge returns to IDLE; bit_cnt holds WIDTH until the next start.
REQ-019 Latency: load_en asserts exactly one cycle after the edge accepting the last bit; minimum start-to-load_en is WIDTH+1 cycles.
REQ-020 d_out changes only on the word-complete edge; d_out is stable for the entire load_en cycle and holds afterwards.
REQ-021 With MSB_FIRST=1, bits b0..b3 (b0 first) produce d_out = {b0,b1,b2,b3}; with MSB_FIRST=0, d_out = {b3,b2,b1,b0}.
REQ-022 start asserted in SHIFT or LOAD is ignored; it is not queued.
REQ-023 abort=1 in SHIFT -> IDLE next edge, bit_cnt cleared to 0, d_out unchanged, no load_en; abort has priority over bit_valid in the same cycle.
REQ-024 abort in LOAD is ignored; the load_en pulse completes.
REQ-025 abort and start both high in IDLE: start wins, word begins.
REQ-026 Back-to-back words: start may be asserted in the cycle load_en is high; it is ignored; the earliest new start is honoured in IDLE.

Reset
REQ-027 reset=0 at a rising edge forces IDLE, d_out=0, load_en=0, busy=0, bit_cnt=0, and clears the shift register, regardless of state.
REQ-028 reset has priority over start, abort and bit_valid; reset asserted mid-word discards the word with no load_en.
REQ-029 The first start is honoured on the first edge with reset=1.

Verification
REQ-030 WIDTH=4, MSB_FIRST=1: start, then bits 1,0,1,1 on 4 consecutive valid cycles -> d_out=4'b1011, load_en high exactly 1 cycle, 5 cycles after start edge.
REQ-031 MSB_FIRST=0, same bits -> d_out=4'b1101.
REQ-032 Bits 1,1,0,1 with bit_valid low for 3 cycles after bit 2 -> d_out=4'b1101, load_en 3 cycles later than without stalls, bit_cnt holds 2 during stall.
REQ-033 abort after 2 bits -> busy drops next edge, bit_cnt=0, d_out retains previous word, no load_en; a following full word loads correctly.
REQ-034 reset=0 after 3 bits -> all outputs 0 on next edge; no load_en ever emitted for that word.
REQ-035 start pulsed during SHIFT and during LOAD -> no effect on bit_cnt, d_out or timing of load_en.
